// File: rtl/mb32_pkg.sv
// Shared definitions for the mb32 multiplier and its downstream dot-product accumulator.
package mb32_pkg;

    localparam int unsigned PROD_W       = 64;
    localparam int unsigned OP_W         = 32;
    localparam int unsigned MULT_LAT_DEF = 2;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    // Widening by the count width keeps a full-length run of max products from wrapping.
    function automatic int unsigned acc_width(int unsigned len_w);
        return PROD_W + len_w;
    endfunction

endpackage

// File: rtl/mb32_dotacc_if.sv
// Run control, operand pacing, product return and result handshake for mb32_dotacc.
interface mb32_dotacc_if
    import mb32_pkg::*;
#(
    parameter int unsigned LEN_W = 8
) ();

    localparam int unsigned ACC_W = acc_width(LEN_W);

    logic              start;
    logic [LEN_W-1:0]  len;
    logic              op_ready;
    logic              op_valid;
    logic [PROD_W-1:0] product;
    logic              busy;
    logic              res_valid;
    logic              res_ready;
    logic [ACC_W-1:0]  result;
    logic              err;

    modport master (
        output start, len, op_valid, product, res_ready,
        input  op_ready, busy, res_valid, result, err
    );

    modport slave (
        input  start, len, op_valid, product, res_ready,
        output op_ready, busy, res_valid, result, err
    );

endinterface

// File: rtl/mb32_vpipe.sv
// 1-bit shift register that tracks which mb32 pipeline slots hold an accepted operand pair.
module mb32_vpipe #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] sr_q;

    // Shift-and-or form works for DEPTH == 1 without a zero-width slice.
    always_ff @(posedge clk) begin
        if (clr) begin
            sr_q <= '0;
        end else begin
            sr_q <= (sr_q << 1) | DEPTH'(d);
        end
    end

    assign q = sr_q[DEPTH-1];

endmodule

// File: rtl/mb32_dotacc.sv
// Dot-product accumulator behind mb32: paces operand issue, tracks products through the
// multiplier latency, sums them and hands the total off on a valid/ready result port.
module mb32_dotacc
    import mb32_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned LEN_W    = 8
) (
    input logic          CLK,
    input logic          RST,
    mb32_dotacc_if.slave bus
);

    localparam int unsigned ACC_W = acc_width(LEN_W);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   issue_q, issue_d;
    logic [LEN_W-1:0]   ret_q, ret_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   result_q, result_d;
    logic               err_q, err_d;

    logic               op_ready;
    logic               accept;
    logic               start_acc;
    logic               dl_out;

    mb32_vpipe #(
        .DEPTH (MULT_LAT)
    ) u_vpipe (
        .clk (CLK),
        .clr (RST),
        .d   (accept),
        .q   (dl_out)
    );

    assign op_ready  = (state_q == ACC) && (issue_q < len_q);
    assign accept    = bus.op_valid && op_ready;
    assign start_acc = bus.start &&
                       ((state_q == IDLE) || ((state_q == DONE) && bus.res_ready));

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        issue_d  = issue_q;
        ret_d    = ret_q;
        acc_d    = acc_q;
        result_d = result_q;
        err_d    = (start_acc ? 1'b0 : err_q) | (bus.op_valid & ~op_ready);

        unique case (state_q)
            IDLE: begin
            end
            ACC: begin
                if (accept) begin
                    issue_d = issue_q + LEN_W'(1);
                end
                if (dl_out) begin
                    acc_d = acc_q + ACC_W'(bus.product);
                    ret_d = ret_q + LEN_W'(1);
                    if (ret_d == len_q) begin
                        state_d  = DONE;
                        result_d = acc_d;
                    end
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A start accepted in IDLE or at the DONE handoff launches the next run directly.
        if (start_acc) begin
            if (bus.len != '0) begin
                state_d = ACC;
                len_d   = bus.len;
                issue_d = '0;
                ret_d   = '0;
                acc_d   = '0;
            end else begin
                state_d  = DONE;
                result_d = '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            len_q    <= '0;
            issue_q  <= '0;
            ret_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            issue_q  <= issue_d;
            ret_q    <= ret_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign bus.op_ready  = op_ready;
    assign bus.busy      = (state_q != IDLE);
    assign bus.res_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.err       = err_q;

endmodule
